// File: rtl/csrng_rsp_pkg.sv
// Shared types and constants for the CSRNG genbits responder.
// Holds the command encodings, header field layout, status codes, default seed and generator step.
package csrng_rsp_pkg;

    typedef enum logic [3:0] {
        ACMD_INV = 4'd0,
        ACMD_INS = 4'd1,
        ACMD_RES = 4'd2,
        ACMD_GEN = 4'd3,
        ACMD_UPD = 4'd4,
        ACMD_UNI = 4'd5
    } acmd_e;

    localparam int ACMD_LSB  = 0;
    localparam int ACMD_W    = 4;
    localparam int CLEN_LSB  = 4;
    localparam int CLEN_W    = 4;
    localparam int FLAGS_LSB = 8;
    localparam int FLAGS_W   = 4;
    localparam int GLEN_LSB  = 12;
    localparam int GLEN_W    = 19;

    localparam logic STS_OK  = 1'b0;
    localparam logic STS_ERR = 1'b1;

    localparam logic [127:0] DEFAULT_SEED = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADATA,
        ST_GEN,
        ST_ACK
    } state_e;

    // Lanes are packed {x,y,z,w} with x in the top 32 bits.
    function automatic logic [127:0] xs128_step(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        x = s[127:96];
        y = s[95:64];
        z = s[63:32];
        w = s[31:0];
        t = x ^ (x << 11);
        return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
    endfunction

endpackage

// File: rtl/csrng_rsp_xorshift128.sv
// xorshift128 state register with seed/xor load, step enable and all-zero guard.
// A load whose result is all-zero falls back to SEED so the generator never locks up.
module csrng_rsp_xorshift128
    import csrng_rsp_pkg::*;
#(
    parameter logic [127:0] SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic         load_from_state,
    input  logic [127:0] load_data,
    input  logic         step_en,
    output logic [127:0] state
);

    logic [127:0] state_q;
    logic [127:0] state_d;
    logic [127:0] load_val;

    always_comb begin
        load_val = (load_from_state ? state_q : SEED) ^ load_data;
        state_d  = state_q;
        if (load_en) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step_en) begin
            state_d = xs128_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/csrng_genbits_rsp.sv
// CSRNG application-port responder: command intake, xorshift128 genbits and ack/status.
// Repetition check of consecutive genbits words is built when CSRNG_RSP_REPEAT_CHECK_EN is defined.
module csrng_genbits_rsp
    import csrng_rsp_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_req_i,
    output logic         cmd_rdy_o,
    input  logic [31:0]  cmd_bus_i,
    output logic         genbits_valid_o,
    input  logic         genbits_rdy_i,
    output logic [127:0] genbits_bus_o,
    output logic         genbits_fips_o,
    output logic         rsp_ack_o,
    output logic         rsp_sts_o,
    input  logic         hold_state_i,
    output logic         repeat_err_o,
    output state_e       dbg_state,
    output logic         dbg_inst
);

    // Handshakes: a word moves on a rising edge where req/valid and rdy are both high;
    // the offering side keeps req/valid and the data stable until that edge.

    state_e              state_q, state_d;
    logic [ACMD_W-1:0]   acmd_q;
    logic [CLEN_W-1:0]   clen_q;
    logic [GLEN_W-1:0]   glen_q;
    logic                flag0_q;
    logic [3:0]          ad_cnt_q;
    logic [127:0]        adata_q;
    logic                inst_q;
    logic                fips_q;
    logic                sts_q;

    logic [ACMD_W-1:0]   bus_acmd;
    logic [CLEN_W-1:0]   bus_clen;
    logic [GLEN_W-1:0]   bus_glen;
    logic                hdr_fire, ad_fire, ad_last, gen_fire, done;
    logic [ACMD_W-1:0]   cur_acmd;
    logic [GLEN_W-1:0]   cur_glen;
    logic                cur_flag0;
    logic [127:0]        adata_cur;
    logic                legal;
    logic                load_en, load_from_state;
    logic [127:0]        load_data;
    logic [127:0]        gen_state;
    logic                rep_hit;

    assign bus_acmd = cmd_bus_i[ACMD_LSB +: ACMD_W];
    assign bus_clen = cmd_bus_i[CLEN_LSB +: CLEN_W];
    assign bus_glen = cmd_bus_i[GLEN_LSB +: GLEN_W];

    assign hdr_fire = cmd_req_i && cmd_rdy_o && (state_q == ST_IDLE);
    assign ad_fire  = cmd_req_i && cmd_rdy_o && (state_q == ST_ADATA);
    assign ad_last  = ad_fire && (ad_cnt_q == (clen_q - 4'd1));
    assign gen_fire = genbits_valid_o && genbits_rdy_i;
    assign done     = (hdr_fire && (bus_clen == '0)) || ad_last;

    // Fields of the command being completed: straight from the bus when there is no adata.
    assign cur_acmd  = hdr_fire ? bus_acmd : acmd_q;
    assign cur_glen  = hdr_fire ? bus_glen : glen_q;
    assign cur_flag0 = hdr_fire ? cmd_bus_i[FLAGS_LSB] : flag0_q;

    always_comb begin
        adata_cur = hdr_fire ? '0 : adata_q;
        if (ad_fire && (ad_cnt_q < 4'd4)) begin
            adata_cur[32*ad_cnt_q[1:0] +: 32] = adata_q[32*ad_cnt_q[1:0] +: 32] ^ cmd_bus_i;
        end
    end

    always_comb begin
        legal = 1'b0;
        case (cur_acmd)
            ACMD_INS: legal = 1'b1;
            ACMD_RES: legal = inst_q;
            ACMD_GEN: legal = inst_q && (cur_glen != '0);
            ACMD_UPD: legal = inst_q;
            ACMD_UNI: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    assign load_en = done && legal &&
                     ((cur_acmd == ACMD_INS) || (cur_acmd == ACMD_RES) ||
                      (cur_acmd == ACMD_UPD) || (cur_acmd == ACMD_UNI));
    assign load_from_state = (cur_acmd == ACMD_UPD);
    assign load_data       = (cur_acmd == ACMD_UNI) ? '0 : adata_cur;

    csrng_rsp_xorshift128 #(
        .SEED (DEFAULT_SEED)
    ) u_gen (
        .clk             (clk_i),
        .rst             (rst_i),
        .load_en         (load_en),
        .load_from_state (load_from_state),
        .load_data       (load_data),
        .step_en         (gen_fire && !hold_state_i),
        .state           (gen_state)
    );

    always_comb begin
        state_d         = state_q;
        cmd_rdy_o       = 1'b0;
        genbits_valid_o = 1'b0;
        rsp_ack_o       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_rdy_o = !rst_i;
                if (hdr_fire) begin
                    if (bus_clen != '0) begin
                        state_d = ST_ADATA;
                    end else begin
                        state_d = (legal && (cur_acmd == ACMD_GEN)) ? ST_GEN : ST_ACK;
                    end
                end
            end
            ST_ADATA: begin
                cmd_rdy_o = !rst_i;
                if (ad_last) begin
                    state_d = (legal && (cur_acmd == ACMD_GEN)) ? ST_GEN : ST_ACK;
                end
            end
            ST_GEN: begin
                genbits_valid_o = 1'b1;
                if (genbits_rdy_i && (glen_q == 19'd1)) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                rsp_ack_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            acmd_q   <= '0;
            clen_q   <= '0;
            glen_q   <= '0;
            flag0_q  <= 1'b0;
            ad_cnt_q <= '0;
            adata_q  <= '0;
            inst_q   <= 1'b0;
            fips_q   <= 1'b0;
            sts_q    <= STS_OK;
        end else begin
            state_q <= state_d;
            if (hdr_fire) begin
                acmd_q   <= bus_acmd;
                clen_q   <= bus_clen;
                glen_q   <= bus_glen;
                flag0_q  <= cmd_bus_i[FLAGS_LSB];
                ad_cnt_q <= '0;
                adata_q  <= '0;
            end
            if (ad_fire) begin
                adata_q  <= adata_cur;
                ad_cnt_q <= ad_cnt_q + 4'd1;
            end
            if (done) begin
                sts_q <= legal ? STS_OK : STS_ERR;
                if (legal && ((cur_acmd == ACMD_INS) || (cur_acmd == ACMD_RES))) begin
                    inst_q <= 1'b1;
                    fips_q <= cur_flag0;
                end
                if (legal && (cur_acmd == ACMD_UNI)) begin
                    inst_q <= 1'b0;
                end
            end
            if (gen_fire) begin
                glen_q <= glen_q - 19'd1;
            end
            if (rep_hit) begin
                sts_q <= STS_ERR;
            end
        end
    end

`ifdef CSRNG_RSP_REPEAT_CHECK_EN
    logic [127:0] last_q;
    logic         have_prev_q;
    logic         repeat_err_q;

    assign rep_hit = gen_fire && have_prev_q && (gen_state == last_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= '0;
            have_prev_q  <= 1'b0;
            repeat_err_q <= 1'b0;
        end else begin
            if (gen_fire) begin
                last_q      <= gen_state;
                have_prev_q <= 1'b1;
            end
            if (rep_hit) begin
                repeat_err_q <= 1'b1;
            end
            // Any reseed starts a fresh sequence; UNI also forgives a past repeat.
            if (load_en) begin
                have_prev_q <= 1'b0;
                if (cur_acmd == ACMD_UNI) begin
                    repeat_err_q <= 1'b0;
                end
            end
        end
    end

    assign repeat_err_o = repeat_err_q;
`else
    assign rep_hit      = 1'b0;
    assign repeat_err_o = 1'b0;
`endif

    assign genbits_bus_o  = gen_state;
    assign genbits_fips_o = fips_q;
    assign rsp_sts_o      = rsp_ack_o && sts_q;
    assign dbg_state      = state_q;
    assign dbg_inst       = inst_q;

endmodule

// File: tb/tb_csrng_genbits_rsp.sv
// Self-checking bench for csrng_genbits_rsp: random commands against a lane-level reference model,
// with a monitor that scores genbits words and ack status from expectation queues.
module tb_csrng_genbits_rsp;
    import csrng_rsp_pkg::*;

    localparam logic [127:0] SEED_C = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_req;
    logic         cmd_rdy;
    logic [31:0]  cmd_bus;
    logic         genbits_valid;
    logic         genbits_rdy;
    logic [127:0] genbits_bus;
    logic         genbits_fips;
    logic         rsp_ack;
    logic         rsp_sts;
    logic         hold_state;
    logic         repeat_err;
    state_e       dbg_state;
    logic         dbg_inst;

    csrng_genbits_rsp dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_req_i       (cmd_req),
        .cmd_rdy_o       (cmd_rdy),
        .cmd_bus_i       (cmd_bus),
        .genbits_valid_o (genbits_valid),
        .genbits_rdy_i   (genbits_rdy),
        .genbits_bus_o   (genbits_bus),
        .genbits_fips_o  (genbits_fips),
        .rsp_ack_o       (rsp_ack),
        .rsp_sts_o       (rsp_sts),
        .hold_state_i    (hold_state),
        .repeat_err_o    (repeat_err),
        .dbg_state       (dbg_state),
        .dbg_inst        (dbg_inst)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic         exp_sts_q[$];
    logic [31:0]  ad_words[$];
    bit           pat[6] = '{1, 0, 0, 1, 0, 1};

`ifdef CSRNG_RSP_REPEAT_CHECK_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    // reference model: generator as four 32-bit lanes, index 0 = x
    int unsigned  m_lane[4];
    bit           m_inst, m_fips, m_rep, m_have_prev;
    logic [127:0] m_last;
    logic [127:0] seed_v;

    function automatic logic [127:0] m_pack();
        return {m_lane[0], m_lane[1], m_lane[2], m_lane[3]};
    endfunction

    task automatic m_load_seed();
        for (int i = 0; i < 4; i++) m_lane[i] = seed_v[127 - 32*i -: 32];
    endtask

    task automatic m_reset();
        m_load_seed();
        m_inst = 0; m_fips = 0; m_rep = 0; m_have_prev = 0; m_last = '0;
    endtask

    task automatic m_step();
        int unsigned x, w, t, nw;
        x  = m_lane[0];
        w  = m_lane[3];
        t  = x ^ (x * 32'd2048);
        nw = w ^ (w / 32'd524288) ^ t ^ (t / 32'd256);
        m_lane[0] = m_lane[1];
        m_lane[1] = m_lane[2];
        m_lane[2] = m_lane[3];
        m_lane[3] = nw;
    endtask

    task automatic m_zero_guard();
        if ((m_lane[0] | m_lane[1] | m_lane[2] | m_lane[3]) == 0) m_load_seed();
    endtask

    task automatic model_cmd(input logic [31:0] hdr, input bit hold);
        int unsigned acmd, glen;
        int unsigned ad[4];
        bit ok, sts;
        logic [127:0] word;
        acmd = hdr[3:0];
        glen = hdr[30:12];
        ad   = '{0, 0, 0, 0};
        for (int k = 0; k < ad_words.size() && k < 4; k++) ad[k] = ad_words[k];
        ok  = 0;
        sts = 0;
        case (acmd)
            1, 2: begin
                ok = (acmd == 1) || m_inst;
                if (ok) begin
                    m_load_seed();
                    for (int k = 0; k < 4; k++) m_lane[3-k] ^= ad[k];
                    m_zero_guard();
                    m_inst = 1; m_fips = hdr[8]; m_have_prev = 0;
                end
            end
            3: begin
                ok = m_inst && (glen != 0);
                if (ok) begin
                    for (int i = 0; i < glen; i++) begin
                        word = m_pack();
                        exp_q.push_back(word);
                        if (REP_ON && m_have_prev && (word == m_last)) begin
                            m_rep = 1; sts = 1;
                        end
                        m_last = word; m_have_prev = 1;
                        if (!hold) m_step();
                    end
                end
            end
            4: begin
                ok = m_inst;
                if (ok) begin
                    for (int k = 0; k < 4; k++) m_lane[3-k] ^= ad[k];
                    m_zero_guard();
                    m_have_prev = 0;
                end
            end
            5: begin
                ok = 1;
                m_load_seed();
                m_inst = 0; m_rep = 0; m_have_prev = 0;
            end
            default: ok = 0;
        endcase
        exp_sts_q.push_back(ok ? sts : 1'b1);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        cmd_req = 1'b1;
        cmd_bus = w;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_rdy && n < 100);
        if (!cmd_rdy) begin
            checks++; errors++;
            $display("FAIL cmd_accept: got no cmd_rdy_o within %0d cycles for word %h", n, w);
        end
        @(posedge clk); #1;
        cmd_req = 1'b0;
    endtask

    task automatic issue(input logic [31:0] hdr, input bit hold, input int rdy_mode);
        int unsigned glen;
        int exp_lat, lat, hs;
        bit gen_ok, seen;
        glen   = hdr[30:12];
        gen_ok = (hdr[3:0] == 4'd3) && m_inst && (glen != 0);
        exp_lat = 1;
        if (gen_ok) begin
            if (rdy_mode == 2) exp_lat = -1;
            else begin
                hs = 0; exp_lat = 0;
                while (hs < int'(glen)) begin
                    exp_lat++;
                    if (rdy_mode == 0 || pat[(exp_lat-1) % 6]) hs++;
                end
                exp_lat++;
            end
        end
        model_cmd(hdr, hold);
        hold_state = hold;
        send_word(hdr);
        foreach (ad_words[k]) send_word(ad_words[k]);
        lat = 0; seen = 0;
        while (!seen && lat < 400) begin
            lat++;
            if (rdy_mode == 0) genbits_rdy = 1'b1;
            else if (rdy_mode == 1) genbits_rdy = pat[(lat-1) % 6];
            else genbits_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_ack) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no rsp_ack_o within %0d cycles for header %h", lat, hdr);
        end else if (exp_lat > 0) begin
            chk("ack_latency", 128'(lat), 128'(exp_lat));
        end
        chk("gen_state", genbits_bus, m_pack());
        chk("inst", 128'(dbg_inst), 128'(m_inst));
        chk("fips", 128'(genbits_fips), 128'(m_fips));
        chk("repeat_err", 128'(repeat_err), 128'(m_rep));
        genbits_rdy = 1'b0;
        hold_state  = 1'b0;
    endtask

    // scoreboard monitor
    initial begin
        logic [127:0] w;
        logic         s;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (genbits_valid && exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL genbits_unexpected: got valid word %h expected none", genbits_bus);
                end else if (genbits_valid && genbits_rdy) begin
                    w = exp_q.pop_front();
                    chk("genbits", genbits_bus, w);
                end
                if (rsp_ack) begin
                    if (exp_sts_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: got ack sts %0b expected no ack", rsp_sts);
                    end else begin
                        s = exp_sts_q.pop_front();
                        chk("rsp_sts", 128'(rsp_sts), 128'(s));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] hdr;
        int unsigned acmd_pick[9];
        acmd_pick = '{1, 2, 3, 3, 3, 4, 5, 0, 7};
        seed_v = SEED_C;
        rst = 1'b1; cmd_req = 1'b0; cmd_bus = '0; genbits_rdy = 1'b0; hold_state = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(genbits_valid), 128'(0));
        chk("rst_ack", 128'(rsp_ack), 128'(0));
        chk("rst_sts", 128'(rsp_sts), 128'(0));
        chk("rst_cmd_rdy", 128'(cmd_rdy), 128'(0));
        chk("rst_fips", 128'(genbits_fips), 128'(0));
        chk("rst_repeat", 128'(repeat_err), 128'(0));
        chk("rst_bus", genbits_bus, SEED_C);
        chk("rst_inst", 128'(dbg_inst), 128'(0));
        m_reset();
        rst = 1'b0;
        @(posedge clk); #1;

        // GEN before instantiation, then INS + GEN with full and toggling ready
        ad_words.delete();
        issue(32'h0000_4003, 0, 0);
        issue(32'h0000_0001, 0, 0);
        issue(32'h0000_4003, 0, 0);
        issue(32'h0000_3003, 0, 1);
        issue(32'h0000_0003, 0, 0);

        // INS with five adata words; the fifth is discarded
        ad_words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        issue(32'h0000_0051, 0, 0);
        chk("ins_adata_state", genbits_bus, SEED_C ^ {32'd4, 32'd3, 32'd2, 32'd1});
        ad_words.delete();

        // held generator: repeat detection and UNI clearing it
        issue(32'h0000_0101, 0, 0);
        issue(32'h0000_3003, 1, 0);
        chk("hold_repeat_flag", 128'(repeat_err), 128'(REP_ON));
        issue(32'h0000_0005, 0, 0);
        chk("uni_clears_repeat", 128'(repeat_err), 128'(0));

        // randomized command stream
        repeat (45) begin
            hdr = '0;
            hdr[3:0]   = 4'(acmd_pick[$urandom_range(0, 8)]);
            hdr[7:4]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 6)) : 4'd0;
            hdr[11:8]  = 4'($urandom_range(0, 15));
            hdr[30:12] = 19'($urandom_range(0, 6));
            ad_words.delete();
            for (int k = 0; k < int'(hdr[7:4]); k++) ad_words.push_back($urandom);
            issue(hdr, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end
        ad_words.delete();

        // reset in the middle of a long GEN
        issue(32'h0000_0001, 0, 0);
        model_cmd(32'h0000_8003, 0);
        send_word(32'h0000_8003);
        genbits_rdy = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b1; genbits_rdy = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", 128'(genbits_valid), 128'(0));
        chk("abort_ack", 128'(rsp_ack), 128'(0));
        chk("abort_sts", 128'(rsp_sts), 128'(0));
        chk("abort_cmd_rdy", 128'(cmd_rdy), 128'(0));
        chk("abort_fips", 128'(genbits_fips), 128'(0));
        chk("abort_repeat", 128'(repeat_err), 128'(0));
        chk("abort_inst", 128'(dbg_inst), 128'(0));
        chk("abort_bus", genbits_bus, SEED_C);
        chk("abort_pending_words", 128'(exp_q.size()), 128'(6));
        exp_q.delete();
        exp_sts_q.delete();
        m_reset();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_ack_after_abort", 128'(rsp_ack), 128'(0));
        end
        @(posedge clk); #1;
        issue(32'h0000_0001, 0, 0);
        issue(32'h0000_2003, 0, 0);

        chk("words_drained", 128'(exp_q.size()), 128'(0));
        chk("acks_drained", 128'(exp_sts_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
